// File: rtl/host_byte_adapter.sv
// ---------------------------------------------------------------------------
// host_byte_adapter
//
// Bridges the 8-bit host byte link and the item-wide host interface arbiter.
//   RX: bytes are packed LSB-first into ITEM_w items, buffered in a small
//       FIFO and offered on item_data_o / item_valid_o / item_avail_i.
//       A partial item that sees no byte for RX_TIMEOUT cycles is discarded
//       (rx_drop_o pulses) so the link resynchronises after a host abort.
//   TX: one item at a time is taken from item_data_i / item_valid_i /
//       item_avail_o and serialised LSB-first onto tx_byte_o.
// A word moves on a rising edge where valid and avail are both high.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   rx_byte_i/_valid_i/_avail_o      byte stream from the host link
//   item_data_o/_valid_o, item_avail_i   assembled items toward the arbiter
//   item_data_i/_valid_i, item_avail_o   items from the arbiter
//   tx_byte_o/_valid_o, tx_byte_avail_i  byte stream toward the host link
//   rx_drop_o                        one-cycle pulse: partial item timed out
// ---------------------------------------------------------------------------
module host_byte_adapter #(
  parameter int ITEM_w     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RX_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte_i,
  input  logic              rx_byte_valid_i,
  output logic              rx_byte_avail_o,
  output logic [ITEM_w-1:0] item_data_o,
  output logic              item_valid_o,
  input  logic              item_avail_i,
  input  logic [ITEM_w-1:0] item_data_i,
  input  logic              item_valid_i,
  output logic              item_avail_o,
  output logic [7:0]        tx_byte_o,
  output logic              tx_byte_valid_o,
  input  logic              tx_byte_avail_i,
  output logic              rx_drop_o
);

  localparam int BYTES = ITEM_w / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BYTES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  // idle_cnt is compared against RX_TIMEOUT-1 so the discard lands on the
  // RX_TIMEOUT-th idle edge after the last accepted byte.
  localparam logic [TO_W-1:0]  IDLE_LAST = TO_W'((RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0);

  // -------------------------------------------------------------------------
  // RX packing and timeout
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt;
  logic [TO_W-1:0]     idle_cnt;
  logic [ITEM_w-9:0]   shreg;      // lanes 0..BYTES-2; the last lane comes straight from rx_byte_i
  logic                rx_take;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [ITEM_w-1:0]   push_data;

  // fifo_full comes from the level register, so accepting a byte never
  // depends combinationally on item_avail_i.
  assign rx_byte_avail_o = !reset && !((cnt == CNT_LAST) && fifo_full);
  assign rx_take         = rx_byte_valid_i && rx_byte_avail_o;
  assign push            = rx_take && (cnt == CNT_LAST);
  assign push_data       = {rx_byte_i, shreg};

  // NOTE: sequential state uses non-blocking assignments so every flop in
  // this block samples values from before the edge, regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      idle_cnt  <= '0;
      rx_drop_o <= 1'b0;
    end else begin
      rx_drop_o <= 1'b0;
      if (rx_take) begin
        // A byte on the discard edge wins: the timer simply restarts.
        idle_cnt <= '0;
        cnt      <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end else if (cnt == '0) begin
        idle_cnt <= '0;
      end else if ((RX_TIMEOUT != 0) && (idle_cnt == IDLE_LAST)) begin
        cnt       <= '0;
        idle_cnt  <= '0;
        rx_drop_o <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // NOTE: pure datapath storage (shift lanes, FIFO array, TX hold) is left
  // unreset; the control state that qualifies it is reset instead.
  always_ff @(posedge clk) begin
    if (rx_take) begin
      for (int k = 0; k < BYTES - 1; k++) begin
        if (cnt == CNT_W'(k)) shreg[8*k +: 8] <= rx_byte_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // RX item FIFO
  // -------------------------------------------------------------------------
  logic [ITEM_w-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;

  assign fifo_empty   = (level == '0);
  assign fifo_full    = (level == LVL_FULL);
  assign item_valid_o = !fifo_empty;
  assign item_data_o  = fifo_empty ? '0 : mem[rd_ptr];
  assign pop          = item_valid_o && item_avail_i;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // TX serialiser
  // -------------------------------------------------------------------------
  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  tx_state_e         tx_state;
  tx_state_e         tx_state_n;
  logic [CNT_W-1:0]  idx;
  logic [ITEM_w-1:0] hold;
  logic              item_take;
  logic              byte_take;

  assign item_take = item_valid_i && item_avail_o;
  assign byte_take = tx_byte_valid_o && tx_byte_avail_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      idx      <= '0;
    end else begin
      tx_state <= tx_state_n;
      if (item_take) idx <= '0;
      else if (byte_take) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (item_take) hold <= item_data_i;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a signal unassigned (no latches).
  always_comb begin
    tx_state_n      = tx_state;
    item_avail_o    = 1'b0;
    tx_byte_valid_o = 1'b0;
    tx_byte_o       = '0;
    case (tx_state)
      TX_IDLE: begin
        item_avail_o = !reset;
        if (item_valid_i && !reset) tx_state_n = TX_SEND;
      end
      TX_SEND: begin
        tx_byte_valid_o = 1'b1;
        tx_byte_o       = hold[{idx, 3'b000} +: 8];
        if (tx_byte_avail_i && (idx == CNT_LAST)) tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

endmodule
